hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, pipeline clock; rst in 1, reset, asynchronous, active-high.
REQ-002 SHALL have inputs: rs1_D, rs2_D in 5, IF/ID source registers; rs1_E, rs2_E, rd_E in 5, ID/EX register fields.
REQ-003 SHALL have inputs: MemRead_E, RegWrite_E in 1; rd_M in 5; RegWrite_M, MemRead_M, MemWrite_M in 1; rd_W in 5; RegWrite_W in 1.
REQ-004 SHALL have inputs: pc_src_E in 1, taken branch/jump/jalr resolved in EX; dmem_ready in 1, data memory completes M-stage access this cycle.
REQ-005 SHALL have outputs: StallF, StallD, StallE, StallM in 1 each; FlushD, FlushE, FlushW in 1 each, all stage-register controls.
REQ-006 SHALL have outputs: ForwardA_E, ForwardB_E out 2, 00 regfile, 10 M-stage result, 01 W-stage result.
REQ-007 SHALL have outputs: mem_timeout out 1, sticky; stall_cycles, flush_events out 32, performance counters.
REQ-008 Parameter TIMEOUT, default 15, max MEM_WAIT cycles before error.

Function
REQ-009 Forwarding SHALL be combinational: ForwardA_E=10 if RegWrite_M && rd_M!=0 && rd_M==rs1_E; else 01 if RegWrite_W && rd_W!=0 && rd_W==rs1_E; else 00. ForwardB_E identical on rs2_E.
REQ-010 Load-use hazard: MemRead_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D) SHALL assert StallF, StallD, FlushE for that cycle (one bubble).
REQ-011 Redirect: pc_src_E SHALL assert FlushD and FlushE and SHALL suppress load-use stall in the same cycle.
REQ-012 mem_busy = (MemRead_M || MemWrite_M) && !dmem_ready; when asserted SHALL assert StallF, StallD, StallE, StallM, FlushW, and SHALL suppress FlushD/FlushE (redirect/load-use re-evaluated once released).
REQ-013 Priority SHALL be ERROR > mem_busy > redirect > load-use > none.
REQ-014 FSM states RUN, MEM_WAIT, ERROR; RUN->MEM_WAIT when mem_busy; MEM_WAIT->RUN when dmem_ready sampled high; MEM_WAIT->ERROR when wait_cnt reaches TIMEOUT with mem_busy still high.
REQ-015 wait_cnt (4 bits min, sized for TIMEOUT) SHALL clear in RUN, increment each MEM_WAIT cycle.
REQ-016 Stall outputs SHALL follow mem_busy combinationally so the cycle dmem_ready is high is a non-stall cycle.
REQ-017 ERROR SHALL hold all Stall* and FlushW high, mem_timeout=1, until reset.
REQ-018 stall_cycles SHALL increment each cycle StallF=1; flush_events each cycle FlushE=1; both wrap modulo 2^32.

Reset
REQ-019 rst SHALL asynchronously force state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_events=0.
REQ-020 While rst is high all Stall*/Flush* outputs SHALL be 0 and ForwardA_E/ForwardB_E SHALL be combinational only.
REQ-021 Reset mid-MEM_WAIT or in ERROR SHALL return to RUN next clk edge after deassertion with no residual stall.

Structure
REQ-022 Shared package SHALL hold hazard state enum, forward-select enum (FWD_REG, FWD_MEM, FWD_WB), and TIMEOUT default.
REQ-023 One sub-module hazard_perf_cnt (two 32-bit wrap counters) SHALL be instantiated; forwarding and FSM stay in hazard_ctrl.

Verification
REQ-024 rd_M=5, RegWrite_M=1, rd_W=5, RegWrite_W=1, rs1_E=5 -> ForwardA_E=10; rd_M=0 same -> 01 from W only if rd_W!=0.
REQ-025 MemRead_E=1, rd_E=7, rs2_D=7 -> StallF=StallD=FlushE=1 one cycle, stall_cycles +1, flush_events +1.
REQ-026 Same as 025 plus pc_src_E=1 -> FlushD=FlushE=1, StallF=StallD=0.
REQ-027 MemRead_M=1, dmem_ready low 3 cycles then high -> Stall*/FlushW high exactly 3 cycles, state returns RUN, mem_timeout=0.
REQ-028 dmem_ready held low 16 cycles with MemWrite_M=1 -> ERROR, mem_timeout=1 sticky; assert rst -> all outputs/counters 0.
REQ-029 Preload stall_cycles to 32'hFFFF_FFFF via forced stall -> one more stall cycle wraps to 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Holds the controller state encoding, the forward-select codes and the memory-wait limit.
package hazard_ctrl_pkg;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int CNT_W           = 32;
  localparam int REG_W           = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Wait counter must hold TIMEOUT itself; never narrower than 4 bits.
  function automatic int wait_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running stall and flush event counters; both wrap modulo 2^32.
module hazard_perf_cnt
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_inc) stall_cycles <= stall_cycles + 1'b1;
      if (flush_inc) flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX operand forwarding, load-use/redirect/memory-wait stalls and flushes.
//   state       | meaning
//   ST_RUN      | normal flow; forwarding, redirect and load-use handling active
//   ST_MEM_WAIT | data memory access outstanding; wait_cnt tracks its age
//   ST_ERROR    | memory access exceeded TIMEOUT; pipeline frozen until reset
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_D,
  input  logic [REG_W-1:0] rs2_D,
  input  logic [REG_W-1:0] rs1_E,
  input  logic [REG_W-1:0] rs2_E,
  input  logic [REG_W-1:0] rd_E,
  input  logic             MemRead_E,
  input  logic             RegWrite_E,
  input  logic [REG_W-1:0] rd_M,
  input  logic             RegWrite_M,
  input  logic             MemRead_M,
  input  logic             MemWrite_M,
  input  logic [REG_W-1:0] rd_W,
  input  logic             RegWrite_W,
  input  logic             pc_src_E,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int                WCNT_W      = wait_cnt_width(TIMEOUT);
  localparam logic [WCNT_W-1:0] TIMEOUT_CNT = WCNT_W'(TIMEOUT);

  hz_state_e         state;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_cnt_inc;
  logic              mem_busy;
  logic              load_use;
  logic              unused_ok;

  // RegWrite_E is part of the stage bundle but no hazard decision depends on it.
  assign unused_ok = RegWrite_E;

  function automatic fwd_sel_e fwd_pick(
    input logic [REG_W-1:0] rs,
    input logic             rw_m,
    input logic [REG_W-1:0] rdm,
    input logic             rw_w,
    input logic [REG_W-1:0] rdw
  );
    if (rw_m && (rdm != '0) && (rdm == rs)) return FWD_MEM;
    if (rw_w && (rdw != '0) && (rdw == rs)) return FWD_WB;
    return FWD_REG;
  endfunction

  assign ForwardA_E = fwd_pick(rs1_E, RegWrite_M, rd_M, RegWrite_W, rd_W);
  assign ForwardB_E = fwd_pick(rs2_E, RegWrite_M, rd_M, RegWrite_W, rd_W);

  assign mem_busy     = (MemRead_M || MemWrite_M) && !dmem_ready;
  assign load_use     = MemRead_E && (rd_E != '0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
  assign wait_cnt_inc = wait_cnt + 1'b1;

  // Controls follow mem_busy directly so the cycle dmem_ready rises is already a moving cycle.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst) begin
      if ((state == ST_ERROR) || mem_busy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (pc_src_E) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wait_cnt <= '0;
          if (mem_busy) state <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          if (!mem_busy) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt_inc == TIMEOUT_CNT) begin
            state       <= ST_ERROR;
            wait_cnt    <= wait_cnt_inc;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        ST_ERROR: begin
          mem_timeout <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  hazard_perf_cnt u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_inc    (StallF),
    .flush_inc    (FlushE),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-level rule model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic        MemRead_E, RegWrite_E, RegWrite_M, MemRead_M, MemWrite_M, RegWrite_W;
  logic        pc_src_E, dmem_ready;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        mem_timeout;
  logic [31:0] stall_cycles, flush_events;

  int checks   = 0;
  int failures = 0;

  // model: consecutive busy cycles, error flag, expected counters
  int          busy_run = 0;
  bit          m_err    = 0;
  logic [31:0] m_stall  = '0;
  logic [31:0] m_flush  = '0;

  hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .MemRead_E(MemRead_E), .RegWrite_E(RegWrite_E),
    .rd_M(rd_M), .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
    .rd_W(rd_W), .RegWrite_W(RegWrite_W),
    .pc_src_E(pc_src_E), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
    if (RegWrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [6:0] ctl_vec();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic set_idle();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    MemRead_E = 0; RegWrite_E = 0; RegWrite_M = 0; MemRead_M = 0; MemWrite_M = 0;
    RegWrite_W = 0; pc_src_E = 0; dmem_ready = 1;
  endtask

  // Called just after a falling edge with inputs applied; checks, advances the model, waits a cycle.
  task automatic tick(input string tag);
    logic busy, ld;
    logic sf, sd, se, sm, fd, fe, fw;
    #1;
    if (rst) begin
      busy_run = 0; m_err = 0; m_stall = '0; m_flush = '0;
    end
    busy = (MemRead_M || MemWrite_M) && !dmem_ready;
    ld   = MemRead_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
    {sf, sd, se, sm, fd, fe, fw} = '0;
    if (!rst) begin
      if (m_err || busy) {sf, sd, se, sm, fw} = '1;
      else if (pc_src_E) {fd, fe} = '1;
      else if (ld) {sf, sd, fe} = '1;
    end
    chk({tag, ".ctl"},   32'(ctl_vec()), 32'({sf, sd, se, sm, fd, fe, fw}));
    chk({tag, ".fwdA"},  32'(ForwardA_E), 32'(fwd_ref(rs1_E)));
    chk({tag, ".fwdB"},  32'(ForwardB_E), 32'(fwd_ref(rs2_E)));
    chk({tag, ".tmo"},   32'(mem_timeout), 32'(m_err));
    chk({tag, ".stall"}, stall_cycles, m_stall);
    chk({tag, ".flush"}, flush_events, m_flush);
    if (!rst) begin
      m_stall = m_stall + 32'(sf);
      m_flush = m_flush + 32'(fe);
      if (!m_err) begin
        if (busy) begin
          busy_run++;
          if (busy_run == TIMEOUT + 1) m_err = 1;
        end else begin
          busy_run = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    tick("reset");
    rst = 1'b0;
    tick("idle");

    // forwarding priority and x0 handling
    rd_M = 5; RegWrite_M = 1; rd_W = 5; RegWrite_W = 1; rs1_E = 5; rs2_E = 5;
    #1 chk("fwd_mem_wins", 32'(ForwardA_E), 32'd2);
    tick("fwd1");
    rd_M = 0;
    #1 chk("fwd_wb_only", 32'(ForwardA_E), 32'd1);
    tick("fwd2");
    rd_W = 0;
    #1 chk("fwd_x0_none", 32'(ForwardA_E), 32'd0);
    tick("fwd3");
    set_idle();

    // load-use bubble, then redirect overriding it
    MemRead_E = 1; rd_E = 7; rs2_D = 7;
    #1 chk("loaduse_ctl", 32'(ctl_vec()), 32'b1100010);
    tick("lu");
    pc_src_E = 1;
    #1 chk("redirect_ctl", 32'(ctl_vec()), 32'b0000110);
    tick("rd");
    set_idle();
    tick("idle2");

    // three-cycle memory wait, released the cycle ready rises
    MemRead_M = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("memwait_ctl", 32'(ctl_vec()), 32'b1111001);
      tick("mw");
    end
    dmem_ready = 1;
    #1 chk("memwait_release", 32'(ctl_vec()), 32'b0000000);
    tick("mwr");
    set_idle();
    tick("idle3");
    chk("memwait_no_tmo", 32'(mem_timeout), 32'd0);

    // timeout into ERROR, sticky until reset
    MemWrite_M = 1; dmem_ready = 0;
    for (int i = 0; i < 16; i++) tick("to");
    dmem_ready = 1; MemWrite_M = 0; pc_src_E = 1;
    #1 chk("err_sticky_tmo", 32'(mem_timeout), 32'd1);
    chk("err_hold_ctl", 32'(ctl_vec()), 32'b1111001);
    tick("err");
    rst = 1'b1;
    #1 chk("rst_ctl", 32'(ctl_vec()), 32'd0);
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    tick("rst_err");
    rst = 1'b0; set_idle();
    tick("post_err");

    // reset in the middle of a memory wait
    MemRead_M = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) tick("mw2");
    rst = 1'b1;
    tick("rst_mw");
    rst = 1'b0; set_idle();
    #1 chk("rst_mw_no_stall", 32'(ctl_vec()), 32'd0);
    tick("post_mw");

    // stall counter wrap from all-ones
    force dut.u_perf.stall_cycles = 32'hFFFF_FFFF;
    m_stall = 32'hFFFF_FFFF;
    tick("preload");
    release dut.u_perf.stall_cycles;
    tick("preload_hold");
    MemRead_E = 1; rd_E = 3; rs1_D = 3;
    tick("wrap_stall");
    set_idle();
    #1 chk("stall_wrap_zero", stall_cycles, 32'd0);
    tick("wrap_after");

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 149) == 0);
      rs1_D      = 5'($urandom_range(0, 7));
      rs2_D      = 5'($urandom_range(0, 7));
      rs1_E      = 5'($urandom_range(0, 7));
      rs2_E      = 5'($urandom_range(0, 7));
      rd_E       = 5'($urandom_range(0, 7));
      rd_M       = 5'($urandom_range(0, 7));
      rd_W       = 5'($urandom_range(0, 7));
      MemRead_E  = 1'($urandom_range(0, 1));
      RegWrite_E = 1'($urandom_range(0, 1));
      RegWrite_M = 1'($urandom_range(0, 1));
      RegWrite_W = 1'($urandom_range(0, 1));
      MemRead_M  = ($urandom_range(0, 3) == 0);
      MemWrite_M = ($urandom_range(0, 3) == 0);
      pc_src_E   = ($urandom_range(0, 3) == 0);
      dmem_ready = (n % 500 < 60) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
